pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
//  Elastic pipeline stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Generalises the plain clocked stage register: parametrised width, valid/ready handshake,
//  a 2-entry skid buffer for full throughput under back-pressure, flush-to-bubble and a
//  saturating stall counter. Sits between two adjacent pipeline stages.
// PARAMETERS
//  WIDTH      32            payload width in bits (data bus = [WIDTH-1:0])
//  NOP_VALUE  {WIDTH{1'b0}} payload driven/held when the stage is empty (bubble; 0 = sll $0)
//  CNT_W      16            width of stall_cnt
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  flush      in   1        discard all held entries at next edge (branch/exception squash)
//  in_valid   in   1        upstream payload valid
//  in_ready   out  1        stage can accept; registered (= !skid_valid)
//  in_data    in   WIDTH    upstream payload
//  out_valid  out  1        payload valid to downstream (= main_valid)
//  out_ready  in   1        downstream accepts
//  out_data   out  WIDTH    payload to downstream (= main_data)
//  occupancy  out  2        entries held: 0, 1 or 2
//  stall_cnt  out  CNT_W    cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready (both sampled same cycle).
//  - States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
//  - EMPTY: push -> ONE, main<=in_data. No push -> stay.
//  - ONE: push&pop -> ONE, main<=in_data; push&!pop -> FULL, skid<=in_data;
//    !push&pop -> EMPTY, main<=NOP_VALUE; neither -> hold.
//  - FULL: in_ready=0 so no push; pop -> ONE, main<=skid, skid<=NOP_VALUE; else hold.
//  - Latency: push in EMPTY -> out_valid=1 next cycle. Throughput 1 item/cycle while
//    out_ready=1. Order strictly FIFO (main before skid).
//  - in_ready depends only on state, never combinationally on out_ready (timing cut).
//  - out_data equals NOP_VALUE whenever out_valid=0.
//  - flush=1: next state EMPTY, main/skid <= NOP_VALUE, occupancy 0. A push in the flush
//    cycle is dropped. A pop in the flush cycle is a completed transfer (downstream
//    already sampled it). flush has priority over push/pop; rst has priority over flush.
//  - rst=1: state EMPTY, main/skid <= NOP_VALUE, out_valid 0, in_ready 1 next cycle,
//    occupancy 0, stall_cnt 0. Reset mid-transfer loses held entries.
//  - stall_cnt: +1 each cycle out_valid&!out_ready (flush cycle included), saturates at
//    2^CNT_W-1, cleared only by rst. Unsigned, no wrap.
//  - X on in_data when in_valid=0 must not propagate into out_data.
// STRUCTURE
//  - Shared include pipe_defs.vh: state encodings (S_EMPTY=2'd0, S_ONE=2'd1,
//    S_FULL=2'd2), default NOP word 32'h0000_0000; reused by all pipeline stage regs.
//  - One sub-module: sat_counter #(CNT_W) (clk, rst, inc, count) for stall_cnt.
//  - Registers: state[1:0], main_data, skid_data; out_valid/in_ready/occupancy decoded
//    from state.
// TESTING
//  - Reset: rst=1 2 cycles -> out_valid=0, in_ready=1, out_data=32'h0, occupancy=0, stall_cnt=0.
//  - Streaming: out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33
//    on cycles 1,2,3, in_ready stays 1, occupancy stays 1.
//  - Back-pressure: out_ready=0, push 0xA1,0xA2 -> occupancy 2, in_ready=0; 3rd push held;
//    release out_ready -> 0xA1 then 0xA2 popped in order, stall_cnt=cycles stalled.
//  - Flush: FULL with 0xB1,0xB2, flush=1 with in_valid=1 (0xB3) -> next cycle out_valid=0,
//    out_data=0x0, occupancy 0; 0xB3 never appears at output.
//  - Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, holds.
//  - Reset mid-op: FULL, assert rst with out_ready=1 -> next cycle EMPTY, no payload out.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
// Holds the occupancy state encoding and the default bubble word.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NopWord = 32'h0000_0000;

    function automatic logic [1:0] occ_of(state_e s);
        case (s)
            StOne:   return 2'd1;
            StFull:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// flush-to-bubble and a saturating back-pressure counter.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NopWord),
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push, pop;

    // in_ready is a pure function of state so out_ready never reaches upstream.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = StFull;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                        main_d  = NOP_VALUE;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule
